uart_alu_host: RTL and testbench

Host-side counterpart of the UART ALU board, for simulation and for board-to-board testing. It takes one operation request (A, B, OPCODE) and serializes it as three 8N1 UART frames on o_tx_data. It then deserializes the single result frame that comes back on i_rx_data and reports it with a done pulse, or reports a timeout or framing error instead.

---
 rtl/uart_alu_host.sv | 256 +++++++++++++++++++++++++
 tb/tb_uart_alu_host.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_host.sv
// Host side of the UART ALU link: sends A, B and OPCODE as three back-to-back 8N1
// frames, then waits for one result frame and reports done, timeout or framing error.
module uart_alu_host #(
    parameter int unsigned BITS           = 8,
    parameter int unsigned OPCODE         = 6,
    parameter int unsigned CLKS_PER_BIT   = 2604,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic              i_Clock,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [BITS-1:0]   i_data_A,
    input  logic [BITS-1:0]   i_data_B,
    input  logic [OPCODE-1:0] i_data_OPCODE,
    input  logic              i_rx_data,
    output logic              o_tx_data,
    output logic              o_busy,
    output logic [BITS-1:0]   o_result,
    output logic              o_done,
    output logic              o_timeout,
    output logic              o_frame_err
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned HALF   = CLKS_PER_BIT / 2;

    typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, SEND_OP, WAIT_RES} state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    state_t              state, state_n;
    rx_state_t           rx_state, rx_state_n;

    logic [BYTE_W-1:0]   a_q, b_q, op_q, cur_byte;
    logic [9:0]          tx_frame;
    logic [3:0]          tx_bit, tx_bit_n, tx_bit_inc;
    logic [CNT_W-1:0]    tx_cnt, tx_cnt_n;
    logic [TMO_W-1:0]    tmo_cnt, tmo_cnt_n;
    logic                tx_n, done_n, tmo_n, ferr_n, load_c;
    logic [BITS-1:0]     result_n;
    logic                pend_vld, pend_vld_n, pend_ok, pend_ok_n;
    logic [BYTE_W-1:0]   pend_byte, pend_byte_n;

    logic                rx_s1, rx_s2, rx_s3;
    logic [CNT_W-1:0]    rx_cnt, rx_cnt_n;
    logic [2:0]          rx_bit, rx_bit_n;
    logic [BYTE_W-1:0]   rx_shift, rx_shift_n;

    logic                bit_end_c, frame_end_c, rx_done_c, tmo_fire_c;

    assign bit_end_c   = (tx_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign frame_end_c = bit_end_c && (tx_bit == 4'd9);
    assign tx_bit_inc  = tx_bit + 4'd1;
    assign tx_frame    = {1'b1, cur_byte, 1'b0};
    // Stop-bit sample cycle; rx_s2 holds the stop bit and rx_shift the full byte.
    assign rx_done_c   = (rx_state == RX_STOP) && (rx_cnt == CNT_W'(CLKS_PER_BIT - 1));
    // A byte finishing in the same cycle takes priority over the timeout.
    assign tmo_fire_c  = (state == WAIT_RES) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) && !rx_done_c;

    always_comb begin
        case (state)
            SEND_A:  cur_byte = a_q;
            SEND_B:  cur_byte = b_q;
            default: cur_byte = op_q;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_reset) begin
        if (!i_reset) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n     = state;
        tx_n        = o_tx_data;
        tx_bit_n    = tx_bit;
        tx_cnt_n    = tx_cnt;
        tmo_cnt_n   = '0;
        pend_vld_n  = pend_vld;
        pend_ok_n   = pend_ok;
        pend_byte_n = pend_byte;
        result_n    = o_result;
        done_n      = 1'b0;
        tmo_n       = 1'b0;
        ferr_n      = 1'b0;
        load_c      = 1'b0;
        case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (i_start) begin
                    load_c     = 1'b1;
                    state_n    = SEND_A;
                    tx_bit_n   = '0;
                    tx_cnt_n   = '0;
                    tx_n       = 1'b0;
                    pend_vld_n = 1'b0;
                end
            end
            SEND_A, SEND_B, SEND_OP: begin
                tx_cnt_n = bit_end_c ? '0 : tx_cnt + 1'b1;
                if (bit_end_c && !frame_end_c) begin
                    tx_bit_n = tx_bit_inc;
                    tx_n     = tx_frame[tx_bit_inc];
                end
                // An early reply is held until the OP frame is fully on the line.
                if (state == SEND_OP && rx_done_c && !pend_vld) begin
                    pend_vld_n  = 1'b1;
                    pend_ok_n   = rx_s2;
                    pend_byte_n = rx_shift;
                end
                if (frame_end_c) begin
                    tx_bit_n = '0;
                    tx_n     = 1'b0;
                    case (state)
                        SEND_A: state_n = SEND_B;
                        SEND_B: state_n = SEND_OP;
                        default: begin
                            tx_n = 1'b1;
                            if (pend_vld || rx_done_c) begin
                                state_n    = IDLE;
                                pend_vld_n = 1'b0;
                                if (pend_vld ? pend_ok : rx_s2) begin
                                    done_n   = 1'b1;
                                    result_n = BITS'(pend_vld ? pend_byte : rx_shift);
                                end else begin
                                    ferr_n = 1'b1;
                                end
                            end else begin
                                state_n = WAIT_RES;
                            end
                        end
                    endcase
                end
            end
            WAIT_RES: begin
                tx_n = 1'b1;
                if (rx_done_c) begin
                    state_n = IDLE;
                    if (rx_s2) begin
                        done_n   = 1'b1;
                        result_n = BITS'(rx_shift);
                    end else begin
                        ferr_n = 1'b1;
                    end
                end else if (tmo_fire_c) begin
                    state_n = IDLE;
                    tmo_n   = 1'b1;
                end else begin
                    tmo_cnt_n = tmo_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_reset) begin
        if (!i_reset) begin
            o_tx_data   <= 1'b1;
            o_busy      <= 1'b0;
            o_result    <= '0;
            o_done      <= 1'b0;
            o_timeout   <= 1'b0;
            o_frame_err <= 1'b0;
            tx_bit      <= '0;
            tx_cnt      <= '0;
            tmo_cnt     <= '0;
            pend_vld    <= 1'b0;
            pend_ok     <= 1'b0;
            pend_byte   <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
        end else begin
            o_tx_data   <= tx_n;
            o_busy      <= (state_n != IDLE);
            o_result    <= result_n;
            o_done      <= done_n;
            o_timeout   <= tmo_n;
            o_frame_err <= ferr_n;
            tx_bit      <= tx_bit_n;
            tx_cnt      <= tx_cnt_n;
            tmo_cnt     <= tmo_cnt_n;
            pend_vld    <= pend_vld_n;
            pend_ok     <= pend_ok_n;
            pend_byte   <= pend_byte_n;
            if (load_c) begin
                a_q  <= BYTE_W'(i_data_A);
                b_q  <= BYTE_W'(i_data_B);
                op_q <= BYTE_W'(i_data_OPCODE);
            end
        end
    end

    // Receiver: synchronizer plus previous-sample flop for falling-edge detection.
    always_ff @(posedge i_Clock or negedge i_reset) begin
        if (!i_reset) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_s3    <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_s1    <= i_rx_data;
            rx_s2    <= rx_s1;
            rx_s3    <= rx_s2;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt + 1'b1;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        if (tmo_fire_c) begin
            rx_state_n = RX_IDLE;
            rx_cnt_n   = '0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt_n = '0;
                    if (rx_s3 && !rx_s2) rx_state_n = RX_START;
                end
                RX_START: begin
                    if (rx_cnt == CNT_W'(HALF - 1)) begin
                        rx_cnt_n   = '0;
                        rx_bit_n   = '0;
                        rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                        rx_cnt_n   = '0;
                        rx_shift_n = {rx_s2, rx_shift[BYTE_W-1:1]};
                        rx_bit_n   = rx_bit + 3'd1;
                        if (rx_bit == 3'd7) rx_state_n = RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (rx_done_c) begin
                        rx_cnt_n   = '0;
                        rx_state_n = RX_IDLE;
                    end
                end
                default: rx_state_n = RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_alu_host.sv
// Scoreboard bench for uart_alu_host: expected TX bytes and result events are queued
// by the driver and compared by independent line/event monitors.
module tb_uart_alu_host;

    localparam int unsigned CPB = 16;
    localparam int unsigned TMO = 400;

    typedef struct {
        int         kind;    // 0 done, 1 timeout, 2 frame error
        logic [7:0] result;
        int         at_cyc;  // -1: any cycle
    } ev_t;

    logic       clk;
    logic       rst_n;
    logic       i_start;
    logic [7:0] i_data_A, i_data_B;
    logic [5:0] i_data_OPCODE;
    logic       i_rx_data;
    logic       o_tx_data, o_busy, o_done, o_timeout, o_frame_err;
    logic [7:0] o_result;

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    ev_t        ev_q[$];
    logic [7:0] tx_q[$];
    ev_t        cur_ev;
    int         act_kind;
    int         tx_st, tx_cnt;
    logic [9:0] tx_frame;

    uart_alu_host #(
        .BITS(8), .OPCODE(6), .CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_Clock(clk), .i_reset(rst_n), .i_start(i_start),
        .i_data_A(i_data_A), .i_data_B(i_data_B), .i_data_OPCODE(i_data_OPCODE),
        .i_rx_data(i_rx_data), .o_tx_data(o_tx_data), .o_busy(o_busy),
        .o_result(o_result), .o_done(o_done), .o_timeout(o_timeout),
        .o_frame_err(o_frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Event monitor: every done/timeout/frame-error pulse must match the queue head.
    always @(negedge clk) begin
        if (rst_n && (o_done || o_timeout || o_frame_err)) begin
            check("evt_onehot", int'(o_done) + int'(o_timeout) + int'(o_frame_err), 1);
            if (ev_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL evt_unexpected actual=done%0b/tmo%0b/ferr%0b required=none (cycle %0d)",
                         o_done, o_timeout, o_frame_err, cyc);
            end else begin
                cur_ev   = ev_q.pop_front();
                act_kind = o_done ? 0 : (o_timeout ? 1 : 2);
                check("evt_kind", act_kind, cur_ev.kind);
                check("evt_result", o_result, cur_ev.result);
                check("evt_busy_low", o_busy, 0);
                if (cur_ev.at_cyc >= 0) check("evt_cycle", cyc, cur_ev.at_cyc);
            end
        end
    end

    // Line monitor: decodes o_tx_data at bit centres and compares with queued bytes.
    always @(negedge clk) begin
        if (!rst_n) begin
            tx_st = 0;
        end else if (tx_st == 0) begin
            if (o_tx_data == 1'b0) begin
                tx_st  = 1;
                tx_cnt = 0;
            end
        end else begin
            tx_cnt++;
            if (tx_cnt % CPB == CPB / 2) begin
                tx_frame[tx_cnt / CPB] = o_tx_data;
                if (tx_cnt / CPB == 9) begin
                    tx_st = 0;
                    check("tx_start_bit", tx_frame[0], 0);
                    check("tx_stop_bit", tx_frame[9], 1);
                    if (tx_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL tx_unexpected_frame actual=0x%0h required=none (cycle %0d)",
                                 tx_frame[8:1], cyc);
                    end else begin
                        check("tx_byte", tx_frame[8:1], tx_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic push_ev(input int kind, input logic [7:0] res, input int at);
        ev_t e;
        e.kind   = kind;
        e.result = res;
        e.at_cyc = at;
        ev_q.push_back(e);
    endtask

    // Issues a request; s is the first cycle of the A start bit.
    task automatic do_start(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                            output int s);
        @(negedge clk);
        i_data_A      = a;
        i_data_B      = b;
        i_data_OPCODE = op;
        i_start       = 1'b1;
        tx_q.push_back(a);
        tx_q.push_back(b);
        tx_q.push_back({2'b00, op});
        s = cyc + 1;
        @(negedge clk);
        i_start = 1'b0;
        check("start_busy", o_busy, 1);
        check("start_bit_low", o_tx_data, 0);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            i_rx_data = f[i];
            repeat (CPB) @(negedge clk);
        end
        i_rx_data = 1'b1;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n;
        n = 0;
        while (o_busy !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle"}, o_busy, 0);
        repeat (4) @(negedge clk);
        check({name, "_ev_drained"}, ev_q.size(), 0);
        check({name, "_tx_drained"}, tx_q.size(), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=running required=finished (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;
        rst_n         = 1'b0;
        i_start       = 1'b0;
        i_data_A      = '0;
        i_data_B      = '0;
        i_data_OPCODE = '0;
        i_rx_data     = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx", o_tx_data, 1);
        check("rst_busy", o_busy, 0);
        check("rst_result", o_result, 0);
        check("rst_done", o_done, 0);
        check("rst_timeout", o_timeout, 0);
        check("rst_frame_err", o_frame_err, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Normal transaction, reply after the request completes.
        do_start(8'h05, 8'h03, 6'h20, s);
        push_ev(0, 8'h08, -1);
        wait_until(s + 485);
        send_byte(8'h08, 1'b1);
        wait_idle("t1", 1000);

        // No reply: timeout 400 cycles after entering WAIT_RES.
        do_start(8'h05, 8'h03, 6'h20, s);
        push_ev(1, 8'h08, s + 480 + TMO);
        wait_idle("t2", 2000);

        // Reply with a bad stop bit.
        do_start(8'h05, 8'h03, 6'h20, s);
        push_ev(2, 8'h08, -1);
        wait_until(s + 485);
        send_byte(8'h3C, 1'b0);
        wait_idle("t3", 1000);

        // Short low glitch before a valid reply.
        do_start(8'h11, 8'h22, 6'h01, s);
        push_ev(0, 8'hFF, -1);
        wait_until(s + 490);
        i_rx_data = 1'b0;
        repeat (4) @(negedge clk);
        i_rx_data = 1'b1;
        repeat (20) @(negedge clk);
        send_byte(8'hFF, 1'b1);
        wait_idle("t4", 1000);

        // Start strobe and operand change while busy are ignored.
        do_start(8'h5A, 8'hC3, 6'h3F, s);
        push_ev(0, 8'h77, -1);
        wait_until(s + 200);
        i_data_A = 8'hAA;
        i_start  = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        check("t5_busy_kept", o_busy, 1);
        wait_until(s + 485);
        send_byte(8'h77, 1'b1);
        wait_idle("t5", 1000);

        // Reply finishing during SEND_OP completes right after the OP stop bit.
        do_start(8'h12, 8'h34, 6'h05, s);
        push_ev(0, 8'h9C, s + 480);
        wait_until(s + 310);
        send_byte(8'h9C, 1'b1);
        wait_idle("t6", 1000);

        // Asynchronous reset in the middle of SEND_B, then a clean transaction.
        do_start(8'h0F, 8'hF0, 6'h2A, s);
        wait_until(s + 200);
        rst_n = 1'b0;
        #1;
        check("t7_async_tx", o_tx_data, 1);
        check("t7_async_busy", o_busy, 0);
        check("t7_async_result", o_result, 0);
        tx_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        do_start(8'h44, 8'h55, 6'h06, s);
        push_ev(0, 8'hE1, -1);
        wait_until(s + 485);
        send_byte(8'hE1, 1'b1);
        wait_idle("t7", 1000);
        check("final_result", o_result, 8'hE1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
